// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU: program memory, PC and a
// single-cycle accumulator write strobe. Optional macro SEQ_SINGLE_STEP_EN adds step_mode/step and a PAUSE state.
module cpu_sequencer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int PROG_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              acc_write_req,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              acc_write_en,
  output logic [ADDR_W-1:0] pc_out,
  output logic              busy,
  output logic              halted,
  output logic [7:0]        instr_count
);

`ifdef SEQ_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4,
    ST_PAUSE   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALTED  = 3'd4
  } state_t;
`endif

  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state_r;
  logic [DATA_W-1:0]   mem_r [PROG_DEPTH];
  logic [DATA_W-1:0]   instr_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                instr_valid_r;
  logic                busy_r;
  logic                halted_r;
  logic [7:0]          instr_count_r;
  logic [3:0]          opcode_s;
  logic                mem_we_s;
  logic                acc_write_en_s;
  logic                to_pause_s;
  logic [7:0]          count_inc_s;

  // Decode helpers: memory write gating, accumulator strobe and retire count.
  always_comb begin
    opcode_s    = instr_r[DATA_W-1 -: 4];
    mem_we_s    = 1'b0;
    count_inc_s = (instr_count_r == 8'hFF) ? 8'hFF : instr_count_r + 8'd1;
    if (!reset && load_en && (state_r == ST_IDLE || state_r == ST_HALTED)) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
    // Strobe follows the decoder's request live in EXECUTE so it lasts exactly that cycle.
    acc_write_en_s = 1'b0;
    if (state_r == ST_EXECUTE && opcode_s != OP_HALT && opcode_s != OP_JMP) begin
      acc_write_en_s = acc_write_req;
    end else begin
      acc_write_en_s = 1'b0;
    end
`ifdef SEQ_SINGLE_STEP_EN
    to_pause_s = step_mode;
`else
    to_pause_s = 1'b0;
`endif
  end

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Sequencer FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= '0;
      instr_r       <= '0;
      instr_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
      instr_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_HALTED: begin
          if (!load_en && start) begin
            state_r       <= ST_FETCH;
            pc_r          <= '0;
            instr_count_r <= 8'd0;
            busy_r        <= 1'b1;
            halted_r      <= 1'b0;
          end
        end
        ST_FETCH: begin
          instr_r       <= mem_r[pc_r];
          instr_valid_r <= 1'b1;
          state_r       <= ST_DECODE;
        end
        ST_DECODE: begin
          state_r <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          instr_valid_r <= 1'b0;
          if (opcode_s == OP_HALT) begin
            state_r  <= ST_HALTED;
            busy_r   <= 1'b0;
            halted_r <= 1'b1;
          end else begin
            pc_r          <= (opcode_s == OP_JMP) ? instr_r[ADDR_W-1:0] : pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            instr_count_r <= count_inc_s;
`ifdef SEQ_SINGLE_STEP_EN
            if (to_pause_s) begin
              state_r <= ST_PAUSE;
              busy_r  <= 1'b0;
            end else begin
              state_r <= ST_FETCH;
            end
`else
            state_r <= to_pause_s ? ST_FETCH : ST_FETCH;
`endif
          end
        end
`ifdef SEQ_SINGLE_STEP_EN
        ST_PAUSE: begin
          if (step || !step_mode) begin
            state_r <= ST_FETCH;
            busy_r  <= 1'b1;
          end
        end
`endif
        default: begin
          state_r       <= ST_IDLE;
          instr_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign instr_out    = instr_r;
  assign instr_valid  = instr_valid_r;
  assign acc_write_en = acc_write_en_s;
  assign pc_out       = pc_r;
  assign busy         = busy_r;
  assign halted       = halted_r;
  assign instr_count  = instr_count_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scoreboard bench for cpu_sequencer; per-instruction expectations are queued before each run.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = 4'd0;
  logic [7:0] load_data = 8'd0;
  logic       acc_write_req = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif
  logic [7:0] instr_out;
  logic       instr_valid;
  logic       acc_write_en;
  logic [3:0] pc_out;
  logic       busy;
  logic       halted;
  logic [7:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] instr;
    logic [3:0] pc;
    logic       req;
    logic       strobe;
    logic [7:0] count;
  } exp_t;

  exp_t sb_q[$];

  cpu_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_en      (load_en),
    .load_addr    (load_addr),
    .load_data    (load_data),
    .acc_write_req(acc_write_req),
`ifdef SEQ_SINGLE_STEP_EN
    .step_mode    (step_mode),
    .step         (step),
`endif
    .instr_out    (instr_out),
    .instr_valid  (instr_valid),
    .acc_write_en (acc_write_en),
    .pc_out       (pc_out),
    .busy         (busy),
    .halted       (halted),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Model: strobe only for non-HALT, non-JMP instructions when the decoder requests it.
  task automatic push(input logic [3:0] pc, input logic [7:0] instr, input logic req, input logic [7:0] count);
    exp_t e;
    e.instr  = instr;
    e.pc     = pc;
    e.req    = req;
    e.strobe = req && (instr[7:4] != 4'hF) && (instr[7:4] != 4'hE);
    e.count  = count;
    sb_q.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in FETCH; walks FETCH, DECODE, EXECUTE and checks against the next queued entry.
  task automatic exec_one();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      acc_write_req = e.req;
      check("fetch_busy", busy, 1);
      check("fetch_strobe", acc_write_en, 0);
      tick();
      check("decode_valid", instr_valid, 1);
      check("decode_strobe", acc_write_en, 0);
      tick();
      check("exec_valid", instr_valid, 1);
      check("exec_instr", instr_out, e.instr);
      check("exec_pc", pc_out, e.pc);
      check("exec_strobe", acc_write_en, e.strobe);
      tick();
      check("retire_count", instr_count, e.count);
      check("after_strobe", acc_write_en, 0);
    end
  endtask

  initial begin
    do_reset();
    check("rst_pc", pc_out, 0);
    check("rst_instr", instr_out, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_strobe", acc_write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_count", instr_count, 0);

    // Program A: one accumulating instruction then HALT.
    load(4'd0, 8'h03);
    load(4'd1, 8'hF0);
    push(4'd0, 8'h03, 1'b1, 8'd1);
    push(4'd1, 8'hF0, 1'b1, 8'd1);
    do_start();
    exec_one();
    exec_one();
    check("a_halted", halted, 1);
    check("a_busy", busy, 0);
    check("a_pc", pc_out, 1);
    check("a_count", instr_count, 1);
    check("a_instr_hold", instr_out, 8'hF0);
    check("a_valid", instr_valid, 0);
    tick();
    check("a_still_halted", halted, 1);

    // Program B loaded while HALTED: 0 -> 1 (JMP 0) loop.
    load(4'd0, 8'h01);
    load(4'd1, 8'hE0);
    load(4'd2, 8'hF0);
    for (int i = 0; i < 6; i++) begin
      push(i[0] ? 4'd1 : 4'd0, i[0] ? 8'hE0 : 8'h01, 1'b1, 8'(i + 1));
    end
    do_start();
    check("b_halted_cleared", halted, 0);
    for (int i = 0; i < 6; i++) exec_one();
    check("b_no_halt", halted, 0);

    // Reset in DECODE aborts the instruction.
    tick();
    check("b_in_decode", instr_valid, 1);
    reset = 1'b1;
    acc_write_req = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_strobe", acc_write_en, 0);
    check("mid_rst_pc", pc_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", instr_valid, 0);
    check("mid_rst_count", instr_count, 0);
    tick();
    check("mid_rst_idle", busy, 0);
    push(4'd0, 8'h01, 1'b0, 8'd1);
    push(4'd1, 8'hE0, 1'b1, 8'd2);
    do_start();
    exec_one();
    exec_one();
    do_reset();

    // load_en wins over start in IDLE; load while busy is dropped.
    load_en = 1'b1; load_addr = 4'd1; load_data = 8'h05; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    check("ld_start_idle", busy, 0);
    check("ld_start_pc", pc_out, 0);
    push(4'd0, 8'h01, 1'b1, 8'd1);
    push(4'd1, 8'h05, 1'b0, 8'd2);
    push(4'd2, 8'hF0, 1'b1, 8'd2);
    do_start();
    load_en = 1'b1; load_addr = 4'd2; load_data = 8'h01; start = 1'b1;
    exec_one();
    load_en = 1'b0; start = 1'b0;
    exec_one();
    exec_one();
    check("busy_load_halted", halted, 1);
    check("busy_load_pc", pc_out, 2);

    // Fill memory with 8'h01 and run past the PC wrap.
    for (int i = 0; i < 16; i++) load(i[3:0], 8'h01);
    for (int i = 0; i < 17; i++) push(i[3:0], 8'h01, 1'b1, 8'(i + 1));
    do_start();
    for (int i = 0; i < 17; i++) exec_one();
    check("wrap_pc", pc_out, 1);
    check("wrap_halted", halted, 0);
    repeat (729) tick();
    check("sat_count", instr_count, 8'hFF);
    check("sat_pc", pc_out, 4);
    check("sat_busy", busy, 1);

`ifdef SEQ_SINGLE_STEP_EN
    do_reset();
    step_mode = 1'b1;
    push(4'd0, 8'h01, 1'b1, 8'd1);
    push(4'd1, 8'h01, 1'b1, 8'd2);
    do_start();
    exec_one();
    check("pause_busy", busy, 0);
    check("pause_pc", pc_out, 1);
    tick();
    tick();
    check("pause_hold_pc", pc_out, 1);
    check("pause_hold_instr", instr_out, 8'h01);
    step = 1'b1;
    tick();
    step = 1'b0;
    exec_one();
    check("step_pc", pc_out, 2);
    check("step_busy", busy, 0);
    step_mode = 1'b0;
`endif

    check("sb_drained", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Fetch/decode/execute controller for the 8-bit accumulator CPU. Holds a small program memory, steps a program counter, and presents one instruction at a time to the decoder. It then issues a single-cycle accumulator write strobe, so the accumulator updates exactly once per instruction instead of combinationally. It sits between the board inputs (program load, start) and the existing decoder/ALU/accumulator datapath.

Parameters:
DATA_W, 8, instruction width; bits [7:4] are the opcode, bits [3:0] are the immediate
ADDR_W, 4, program counter / memory address width
PROG_DEPTH, 16, program memory entries (2**ADDR_W)

Ports:
clk  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level-sampled; begins execution from address 0 when IDLE or HALTED
load_en  input  1  write load_data into program memory at load_addr
load_addr  input  ADDR_W  program memory write address
load_data  input  DATA_W  program memory write data
acc_write_req  input  1  decoder's "result goes to accumulator" flag for the current instruction
instr_out  output  DATA_W  instruction register, drives decoder instruction input
instr_valid  output  1  high while instr_out holds a fetched instruction (DECODE, EXECUTE)
acc_write_en  output  1  one-cycle accumulator write strobe
pc_out  output  ADDR_W  current program counter
busy  output  1  high in FETCH, DECODE, EXECUTE
halted  output  1  high in HALTED
instr_count  output  8  number of retired instructions since the last start

Behaviour:
- Reset (synchronous, active-high, wins over everything):
  - state=IDLE, pc_out=0, instr_out=0, instr_valid=0, acc_write_en=0, busy=0, halted=0, instr_count=0.
  - Program memory contents are NOT cleared.
  - Reset mid-instruction aborts it; no acc_write_en is issued.
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- IDLE:
  - load_en=1 writes memory and takes priority: a start in the same cycle is ignored.
  - Else start=1 -> FETCH with pc=0, instr_count=0.
- FETCH: instr_out <= mem[pc]; -> DECODE.
- DECODE: instr_valid=1, one cycle for decoder/ALU to settle; -> EXECUTE.
- EXECUTE: instr_valid=1. Opcode handling:
  - Opcode 4'hF (HALT): no strobe, pc unchanged, -> HALTED.
  - Opcode 4'hE (JMP): pc <= immediate, no strobe, instr_count+1, -> FETCH.
  - Otherwise: acc_write_en = acc_write_req for this cycle only. pc <= pc+1 (wraps 15->0, no halt on wrap). instr_count+1 (saturates at 255). -> FETCH.
- Timing:
  - Latency is 3 cycles per instruction.
  - acc_write_en is never high outside EXECUTE, and never two consecutive cycles.
- HALTED:
  - halted=1; instr_out holds the HALT instruction; instr_valid=0.
  - load_en is accepted. start restarts exactly as from IDLE.
- load_en while busy: ignored, memory unchanged.
- start while busy: ignored.
- acc_write_req is sampled only in EXECUTE.

Optional Feature:
SEQ_SINGLE_STEP_EN:
- Defined: adds inputs step_mode (1) and step (1), plus a PAUSE state.
  - With step_mode=1, EXECUTE (non-HALT) goes to PAUSE instead of FETCH.
  - PAUSE holds pc and instr_out, with busy=0.
  - A step=1 cycle in PAUSE -> FETCH.
  - step_mode=0 in PAUSE -> FETCH on the next cycle.
  - load_en is ignored in PAUSE.
- Undefined: no extra ports or state; behaviour exactly as above.

Test Plan:
- Load mem[0]=8'h03, mem[1]=8'hF0; start with acc_write_req=1 -> one acc_write_en pulse 3 cycles after FETCH entry, then halted=1, pc_out=1, instr_count=1.
- Load mem[0..2]=8'h01,8'hE0,8'hF0 -> pc sequence 0,1,0,1,..., never halts; instr_count increments by 1 every 3 cycles; no strobe on the JMP instruction.
- Fill all 16 entries with 8'h01; run 17 instructions -> pc wraps 15->0; pc_out=1 after the 17th; no halt.
- Assert reset in DECODE -> next cycle state IDLE, acc_write_en=0, pc_out=0; memory read-back after restart is unchanged.
- load_en=1 and start=1 in the same IDLE cycle -> memory written, still IDLE; load_en while busy -> memory unchanged.
- SEQ_SINGLE_STEP_EN defined, step_mode=1 -> stalls in PAUSE after each instruction; each step pulse advances pc by exactly 1.
